// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, one outstanding imem read, 2-entry {pc, instr} FIFO to decode.
// Define BTFN_PRED_EN to add static backward-taken prediction on popped words (pred_taken port).
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_LAT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    output logic            chng2nop,
`ifdef BTFN_PRED_EN
    output logic            pred_taken,
`endif
    output logic            fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam int            CW   = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_LAT - 1);

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_req;
    logic [CW-1:0]   lat_cnt;
    logic [1:0]      count;
    logic [XLEN-1:0] pc_q  [2];
    logic [31:0]     ins_q [2];

    logic            pop;
    logic            push;
    logic            room_after;
    logic            wr_slot;
    logic            flush;
    logic            timeout;
    logic [XLEN-1:0] flush_pc;

    assign instr_valid = (count != 2'd0);
    assign instr_out   = instr_valid ? ins_q[0] : 32'h0;
    assign pc_out      = instr_valid ? pc_q[0] : '0;
    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;

    assign pop        = instr_valid && !stall;
    assign room_after = (count == 2'd0) || (count == 2'd1 && pop);
    assign wr_slot    = !room_after;
    assign push       = (state == S_WAIT) && imem_rvalid && !flush;
    assign timeout    = (state == S_WAIT || state == S_DROP) && !imem_rvalid && (lat_cnt == LAST);

`ifdef BTFN_PRED_EN
    logic [31:0] head;
    logic [31:0] jal_imm;
    logic [31:0] br_imm;
    logic        is_jal;
    logic        is_bneg;
    logic        taken;

    // NOTE: every signal is assigned on every pass, so no latch can be inferred.
    always_comb begin
        head    = ins_q[0];
        jal_imm = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};
        br_imm  = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
        is_jal  = (head[6:0] == 7'b1101111);
        is_bneg = (head[6:0] == 7'b1100011) && head[31];
        taken   = instr_valid && (is_jal || is_bneg);
    end

    // A predicted-taken pop behaves like a redirect except that decode is not squashed.
    assign pred_taken = taken;
    assign flush      = redirect || (pop && taken);
    assign flush_pc   = redirect ? redirect_pc
                                 : pc_q[0] + XLEN'($signed(is_jal ? jal_imm : br_imm));
`else
    assign flush    = redirect;
    assign flush_pc = redirect_pc;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            pc_req    <= RESET_PC;
            lat_cnt   <= '0;
            count     <= 2'd0;
            chng2nop  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            chng2nop <= redirect;
            if (flush) begin
                count <= 2'd0;
                pc    <= flush_pc;
            end else begin
                count <= count + 2'(push) - 2'(pop);
            end
            if (timeout) fetch_err <= 1'b1;
            if ((state == S_WAIT || state == S_DROP) && lat_cnt != LAST)
                lat_cnt <= lat_cnt + CW'(1);

            case (state)
                S_IDLE: if (!flush && count != 2'd2) state <= S_REQ;
                S_REQ: begin
                    lat_cnt <= '0;
                    // A grant in the redirect cycle leaves a response in flight that must be drained.
                    if (flush) begin
                        state <= imem_gnt ? S_DROP : S_IDLE;
                    end else if (imem_gnt) begin
                        pc_req <= pc;
                        pc     <= pc + XLEN'(4);
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= imem_rvalid ? S_REQ : S_DROP;
                    end else if (imem_rvalid) begin
                        state <= room_after ? S_REQ : S_IDLE;
                    end else if (timeout) begin
                        pc    <= pc_req;
                        state <= S_REQ;
                    end
                end
                S_DROP: if (imem_rvalid || timeout) state <= S_REQ;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; count alone decides which slots hold real data.
    always_ff @(posedge clk) begin
        if (pop) begin
            pc_q[0]  <= pc_q[1];
            ins_q[0] <= ins_q[1];
        end
        if (push) begin
            pc_q[wr_slot]  <= pc_req;
            ins_q[wr_slot] <= imem_rdata;
        end
    end

endmodule
